seq_multiplier: RTL
===================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; the product is 2*WIDTH bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-004 SHALL have port e, input, 1 bit, enable; when low, all internal state and outputs hold.
REQ-005 SHALL have port start, input, 1 bit, request to begin a multiply with the current A and B.
REQ-006 SHALL have port A, input, WIDTH bits, unsigned multiplicand (operand held at address 0 upstream).
REQ-007 SHALL have port B, input, WIDTH bits, unsigned multiplier (operand held at address 1 upstream).
REQ-008 SHALL have port P, output, 2*WIDTH bits, registered product of the last completed operation.
REQ-009 SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit, one-cycle pulse marking that P has just been updated.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-012 In IDLE, on an edge with e=1 and start=1, SHALL latch A zero-extended to 2*WIDTH as mcand, latch B as mplr, clear acc and count, and enter RUN.
REQ-013 In RUN, each edge with e=1 SHALL add mcand to acc if mplr[0]=1, shift mcand left 1, shift mplr right 1 logically, and increment count.
REQ-014 After the WIDTH-th RUN iteration, SHALL load P with the final acc value and enter DONE on that same edge.
REQ-015 In DONE, SHALL assert done for exactly one e=1 cycle, then return to IDLE.
REQ-016 Latency: if start is sampled at edge N with e held high, done SHALL be high during the cycle after edge N+WIDTH, and P SHALL be valid from that edge onward.
REQ-017 busy SHALL be high exactly while the state is RUN.
REQ-018 start SHALL be ignored in RUN and DONE; it SHALL NOT restart or corrupt an operation in flight.
REQ-019 A and B SHALL be sampled only at the start edge; input changes during RUN SHALL NOT affect the result.
REQ-020 Arithmetic SHALL be unsigned, and acc SHALL be 2*WIDTH bits with no overflow possible; the maximum is (2^WIDTH-1)^2.
REQ-021 P SHALL hold its value until the next completion and SHALL NOT change in IDLE or RUN.
REQ-022 When e=0, state, count, acc and P SHALL freeze, done SHALL hold its value, and the operation SHALL resume when e returns high.
REQ-023 A start in the same cycle that done is high SHALL be ignored; a new start is accepted only from IDLE, the cycle after DONE.
REQ-024 A zero operand SHALL still take the full WIDTH iterations and yield P=0; there is no early termination.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, P=0, busy=0, done=0, acc=0 and count=0, regardless of clk or e.
REQ-026 A reset during RUN SHALL abort the operation, with no done pulse and P=0; start is accepted normally once rst is released.

Verification
REQ-027 Basic multiply: A=4, B=5, start pulse, e=1 -> busy high for 16 cycles, then done pulse with P=20 (0x00000014).
REQ-028 Mid-range operands: A=445, B=100 -> P=44500 (0x0000ADD4), and done arrives exactly 16 edges after the start edge.
REQ-029 Maximum operands: A=65535, B=65535 -> P=4294836225 (0xFFFE0001). A=0, B=1234 -> P=0 after the full latency.
REQ-030 Start while busy: start A=4, B=5; at RUN cycle 5 change A=7, B=9 and pulse start -> result is still P=20, with a single done pulse.
REQ-031 Reset mid-operation: assert rst at RUN cycle 8 -> P=0, busy=0 and done=0 at once. Then A=3, B=3 with start -> P=9.
REQ-032 Enable stall: drop e for 5 cycles during RUN -> done is delayed by exactly 5 cycles and P is still correct (A=445, B=100 -> 44500).

Source files
------------

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier
//  Function : Unsigned shift-and-add multiplier. One multiplier bit is
//             consumed per enabled clock, so a product takes WIDTH cycles,
//             followed by a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               e,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] P,
   output logic               busy,
   output logic               done
);

   // Counter wide enough for 0..WIDTH so WIDTH=1 still gets a legal width
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] C_LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q,  state_d;
   logic [2*WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0]   mplr_q,   mplr_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;
   logic [CW-1:0]      count_q,  count_d;
   logic [2*WIDTH-1:0] p_q,      p_d;
   logic               done_q,   done_d;

   // Partial sum for the current iteration; also the final product on the last one
   logic [2*WIDTH-1:0] w_acc_sum;
   assign w_acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);

   // Next-state and datapath: everything holds unless enable is high
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      acc_d   = acc_q;
      count_d = count_q;
      p_d     = p_q;
      done_d  = done_q;

      if (e) begin
         unique case (state_q)
            IDLE: begin
               done_d = 1'b0;
               if (start) begin
                  mcand_d = {{WIDTH{1'b0}}, A};
                  mplr_d  = B;
                  acc_d   = '0;
                  count_d = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               // start is deliberately not examined here: an operation in
               // flight cannot be restarted or disturbed
               acc_d   = w_acc_sum;
               mcand_d = mcand_q << 1;
               mplr_d  = mplr_q >> 1;
               count_d = count_q + 1'b1;
               if (count_q == C_LAST_ITER) begin
                  p_d     = w_acc_sum;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
            DONE: begin
               // A start seen here is dropped; a new one is taken from IDLE
               done_d  = 1'b0;
               state_d = IDLE;
            end
            default: begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         endcase
      end
   end

   // State register with asynchronous reset that also aborts any operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         count_q <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   assign P    = p_q;
   assign busy = (state_q == RUN);
   assign done = done_q;

endmodule
`default_nettype wire
